// File: rtl/screg_pkg.sv
// Shared types for SC register-bus blocks: bus struct, AXI response codes,
// and the bridge channel state encodings.
package screg_pkg;

   typedef struct packed {
      logic [31:0] wadr;
      logic [9:0]  wtyp;
      logic [3:0]  wenb;
      logic [31:0] wdat;
      logic        wwat;
      logic        werr;
      logic [31:0] radr;
      logic [9:0]  rtyp;
      logic        renb;
      logic [31:0] rdat;
      logic        rwat;
      logic        rerr;
   } sc_regbus_t;

   localparam logic [1:0] SC_RESP_OKAY   = 2'b00;
   localparam logic [1:0] SC_RESP_SLVERR = 2'b10;
   localparam logic [1:0] SC_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_BUS  = 2'd1,
      W_RESP = 2'd2
   } sc_wstate_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_BUS  = 2'd1,
      R_RESP = 2'd2
   } sc_rstate_t;

endpackage

// File: rtl/sc_regbus_tmo.sv
// Wait-cycle counter for one bridge channel; expire pulses in the waited
// cycle that brings the count up to TIMEOUT.
module sc_regbus_tmo
   import screg_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Count waited cycles; held at zero whenever the channel is not on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (waiting)
         cnt <= cnt + CW'(1);
   end

   assign expire = waiting && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sc_axil2regbus.sv
// AXI4-Lite subordinate bridged onto the SC register bus. Independent write
// and read channels, each with its own FSM and wait-timeout counter.
module sc_axil2regbus
   import screg_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [ADDR_WIDTH-1:0] S_AWADDR,
   input  logic [2:0]            S_AWPROT,
   input  logic                  S_AWVALID,
   output logic                  S_AWREADY,
   input  logic [31:0]           S_WDATA,
   input  logic [3:0]            S_WSTRB,
   input  logic                  S_WVALID,
   output logic                  S_WREADY,
   output logic [1:0]            S_BRESP,
   output logic                  S_BVALID,
   input  logic                  S_BREADY,
   input  logic [ADDR_WIDTH-1:0] S_ARADDR,
   input  logic [2:0]            S_ARPROT,
   input  logic                  S_ARVALID,
   output logic                  S_ARREADY,
   output logic [31:0]           S_RDATA,
   output logic [1:0]            S_RRESP,
   output logic                  S_RVALID,
   input  logic                  S_RREADY,
   output sc_regbus_t            REGBUS_O,
   input  sc_regbus_t            REGBUS_I
);

   // write channel state
   sc_wstate_t            wstate, wstate_d;
   logic                  aw_full, aw_full_d, w_full, w_full_d;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [2:0]            awprot_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  awready_q, wready_q, bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [31:0]           wadr_q, wadr_d, wdat_q, wdat_d;
   logic [9:0]            wtyp_q, wtyp_d;
   logic [3:0]            wenb_q, wenb_d;
   logic                  aw_hs, w_hs, w_waiting, w_expire;
   logic [31:0]           aw_addr_sel, w_data_sel;
   logic [2:0]            aw_prot_sel;
   logic [3:0]            w_strb_sel;

   // read channel state
   sc_rstate_t            rstate, rstate_d;
   logic                  arready_q, rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [31:0]           rdata_q, rdata_d, radr_q, radr_d;
   logic [9:0]            rtyp_q, rtyp_d;
   logic                  renb_q, renb_d;
   logic                  ar_hs, r_waiting, r_expire;

   logic                  unused_regbus;

   assign aw_hs = S_AWVALID && awready_q;
   assign w_hs  = S_WVALID && wready_q;
   assign ar_hs = S_ARVALID && arready_q;

   // AW and W may arrive together: take the live bus value over the holding register.
   assign aw_addr_sel = 32'(aw_hs ? S_AWADDR : awaddr_q);
   assign aw_prot_sel = aw_hs ? S_AWPROT : awprot_q;
   assign w_data_sel  = w_hs ? S_WDATA : wdata_q;
   assign w_strb_sel  = w_hs ? S_WSTRB : wstrb_q;

   assign w_waiting = (wstate == W_BUS) && REGBUS_I.wwat;
   assign r_waiting = (rstate == R_BUS) && REGBUS_I.rwat;

   sc_regbus_tmo #(.TIMEOUT(TIMEOUT)) u_wtmo (
      .clk     (CLK),
      .rst_n   (RSTn),
      .clear   (wstate != W_BUS),
      .waiting (w_waiting),
      .expire  (w_expire)
   );

   sc_regbus_tmo #(.TIMEOUT(TIMEOUT)) u_rtmo (
      .clk     (CLK),
      .rst_n   (RSTn),
      .clear   (rstate != R_BUS),
      .waiting (r_waiting),
      .expire  (r_expire)
   );

   // Write FSM next state and next values of the registered write outputs.
   always_comb begin
      wstate_d  = wstate;
      aw_full_d = aw_full;
      w_full_d  = w_full;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      wadr_d    = wadr_q;
      wdat_d    = wdat_q;
      wtyp_d    = wtyp_q;
      wenb_d    = wenb_q;
      case (wstate)
         W_IDLE: begin
            if (aw_hs) aw_full_d = 1'b1;
            if (w_hs)  w_full_d  = 1'b1;
            if (aw_full_d && w_full_d) begin
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
               if (w_strb_sel == 4'd0) begin
                  // nothing to write: answer without touching the bus
                  wstate_d = W_RESP;
                  bvalid_d = 1'b1;
                  bresp_d  = SC_RESP_OKAY;
               end else begin
                  wstate_d = W_BUS;
                  wadr_d   = aw_addr_sel & 32'hFFFF_FFFC;
                  wdat_d   = w_data_sel;
                  wtyp_d   = {7'b0, aw_prot_sel};
                  wenb_d   = w_strb_sel;
               end
            end
         end
         W_BUS: begin
            if (!REGBUS_I.wwat) begin
               wenb_d   = 4'd0;
               wstate_d = W_RESP;
               bvalid_d = 1'b1;
               bresp_d  = REGBUS_I.werr ? SC_RESP_SLVERR : SC_RESP_OKAY;
            end else if (w_expire) begin
               wenb_d   = 4'd0;
               wstate_d = W_RESP;
               bvalid_d = 1'b1;
               bresp_d  = SC_RESP_DECERR;
            end
         end
         W_RESP: begin
            if (S_BREADY) begin
               bvalid_d = 1'b0;
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Write FSM and its registered outputs; reset drops the bus strobe at once.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wstate    <= W_IDLE;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= SC_RESP_OKAY;
         wadr_q    <= '0;
         wdat_q    <= '0;
         wtyp_q    <= '0;
         wenb_q    <= '0;
      end else begin
         wstate    <= wstate_d;
         aw_full   <= aw_full_d;
         w_full    <= w_full_d;
         awready_q <= (wstate_d == W_IDLE) && !aw_full_d;
         wready_q  <= (wstate_d == W_IDLE) && !w_full_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         wadr_q    <= wadr_d;
         wdat_q    <= wdat_d;
         wtyp_q    <= wtyp_d;
         wenb_q    <= wenb_d;
      end
   end

   // Holding registers for AW and W beats that arrive on their own.
   always_ff @(posedge CLK) begin
      if (aw_hs) begin
         awaddr_q <= S_AWADDR;
         awprot_q <= S_AWPROT;
      end
      if (w_hs) begin
         wdata_q <= S_WDATA;
         wstrb_q <= S_WSTRB;
      end
   end

   // Read FSM next state and next values of the registered read outputs.
   always_comb begin
      rstate_d = rstate;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      radr_d   = radr_q;
      rtyp_d   = rtyp_q;
      renb_d   = renb_q;
      case (rstate)
         R_IDLE: begin
            if (ar_hs) begin
               rstate_d = R_BUS;
               radr_d   = 32'(S_ARADDR);
               rtyp_d   = {7'b0, S_ARPROT};
               renb_d   = 1'b1;
            end
         end
         R_BUS: begin
            if (!REGBUS_I.rwat) begin
               renb_d   = 1'b0;
               rstate_d = R_RESP;
               rvalid_d = 1'b1;
               rdata_d  = REGBUS_I.rdat;
               rresp_d  = REGBUS_I.rerr ? SC_RESP_SLVERR : SC_RESP_OKAY;
            end else if (r_expire) begin
               renb_d   = 1'b0;
               rstate_d = R_RESP;
               rvalid_d = 1'b1;
               rdata_d  = '0;
               rresp_d  = SC_RESP_DECERR;
            end
         end
         R_RESP: begin
            if (S_RREADY) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Read FSM and its registered outputs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rstate    <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= SC_RESP_OKAY;
         rdata_q   <= '0;
         radr_q    <= '0;
         rtyp_q    <= '0;
         renb_q    <= 1'b0;
      end else begin
         rstate    <= rstate_d;
         arready_q <= (rstate_d == R_IDLE);
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         radr_q    <= radr_d;
         rtyp_q    <= rtyp_d;
         renb_q    <= renb_d;
      end
   end

   // Request fields driven from registers; the response fields stay zero.
   always_comb begin
      REGBUS_O      = '0;
      REGBUS_O.wadr = wadr_q;
      REGBUS_O.wtyp = wtyp_q;
      REGBUS_O.wenb = wenb_q;
      REGBUS_O.wdat = wdat_q;
      REGBUS_O.radr = radr_q;
      REGBUS_O.rtyp = rtyp_q;
      REGBUS_O.renb = renb_q;
   end

   assign unused_regbus = ^{REGBUS_I.wadr, REGBUS_I.wtyp, REGBUS_I.wenb, REGBUS_I.wdat,
                            REGBUS_I.radr, REGBUS_I.rtyp, REGBUS_I.renb};

   assign S_AWREADY = awready_q;
   assign S_WREADY  = wready_q;
   assign S_BVALID  = bvalid_q;
   assign S_BRESP   = bresp_q;
   assign S_ARREADY = arready_q;
   assign S_RVALID  = rvalid_q;
   assign S_RRESP   = rresp_q;
   assign S_RDATA   = rdata_q;

endmodule

// File: tb/tb_sc_axil2regbus.sv
// Bench for sc_axil2regbus: table-driven writes/reads against a scripted
// register-block responder, a response scoreboard, and hand sequences for
// concurrency, backpressure and mid-transaction reset.
module tb_sc_axil2regbus;
   import screg_pkg::*;

   localparam int TMO = 8;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b0;
   logic [31:0] S_AWADDR = '0;
   logic [2:0]  S_AWPROT = '0;
   logic        S_AWVALID = 1'b0;
   logic        S_AWREADY;
   logic [31:0] S_WDATA = '0;
   logic [3:0]  S_WSTRB = '0;
   logic        S_WVALID = 1'b0;
   logic        S_WREADY;
   logic [1:0]  S_BRESP;
   logic        S_BVALID;
   logic        S_BREADY = 1'b1;
   logic [31:0] S_ARADDR = '0;
   logic [2:0]  S_ARPROT = '0;
   logic        S_ARVALID = 1'b0;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY = 1'b1;
   sc_regbus_t  REGBUS_O;
   sc_regbus_t  REGBUS_I;

   int total = 0;
   int bad   = 0;

   // responder script
   int          w_wait_req = 0;
   int          r_wait_req = 0;
   bit          w_err = 1'b0;
   bit          r_err = 1'b0;
   logic [31:0] r_dat = '0;
   int          w_cnt = 0;
   int          r_cnt = 0;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } rexp_t;

   logic [1:0] bq[$];
   rexp_t      rq[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          wlead;
      int          nwait;
      bit          err;
      logic [1:0]  exp_resp;
      int          exp_strobes;
      int          exp_bcyc;
   } wvec_t;

   typedef struct {
      logic [31:0] addr;
      int          nwait;
      logic [31:0] rdat;
      bit          err;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
      int          exp_renb;
      int          exp_rcyc;
   } rvec_t;

   wvec_t wv[5];
   rvec_t rv[4];

   always #5 CLK = ~CLK;

   sc_axil2regbus #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .S_AWADDR  (S_AWADDR),
      .S_AWPROT  (S_AWPROT),
      .S_AWVALID (S_AWVALID),
      .S_AWREADY (S_AWREADY),
      .S_WDATA   (S_WDATA),
      .S_WSTRB   (S_WSTRB),
      .S_WVALID  (S_WVALID),
      .S_WREADY  (S_WREADY),
      .S_BRESP   (S_BRESP),
      .S_BVALID  (S_BVALID),
      .S_BREADY  (S_BREADY),
      .S_ARADDR  (S_ARADDR),
      .S_ARPROT  (S_ARPROT),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY),
      .REGBUS_O  (REGBUS_O),
      .REGBUS_I  (REGBUS_I)
   );

   // count how long each strobe has been up
   always @(posedge CLK) begin
      w_cnt <= (REGBUS_O.wenb != 4'd0) ? w_cnt + 1 : 0;
      r_cnt <= REGBUS_O.renb ? r_cnt + 1 : 0;
   end

   // register block: wait for the scripted number of cycles, then answer
   always_comb begin
      REGBUS_I      = '0;
      REGBUS_I.wwat = (REGBUS_O.wenb != 4'd0) && (w_cnt < w_wait_req);
      REGBUS_I.werr = w_err;
      REGBUS_I.rwat = REGBUS_O.renb && (r_cnt < r_wait_req);
      REGBUS_I.rerr = r_err;
      REGBUS_I.rdat = r_dat;
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int wlead, input int nwait, input bit err, input int bp,
                           input logic [1:0] exp_resp, input int exp_strobes, input int exp_bcyc);
      int          strobes = 0;
      int          bv_cyc = -1;
      int          hold = 0;
      bit          done = 1'b0;
      bit          aw_f, w_f;
      logic [3:0]  s_wenb = '0;
      logic [31:0] s_adr = '0;
      logic [31:0] s_dat = '0;
      logic [9:0]  s_typ = '0;
      logic [1:0]  e;
      w_wait_req = nwait;
      w_err      = err;
      bq.push_back(exp_resp);
      S_AWADDR  = a;
      S_AWPROT  = 3'd5;
      S_WDATA   = d;
      S_WSTRB   = s;
      S_WVALID  = 1'b1;
      S_AWVALID = (wlead == 0);
      S_BREADY  = (bp == 0);
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge CLK);
         if (REGBUS_O.wenb != 4'd0) begin
            if (strobes == 0) begin
               s_wenb = REGBUS_O.wenb;
               s_adr  = REGBUS_O.wadr;
               s_dat  = REGBUS_O.wdat;
               s_typ  = REGBUS_O.wtyp;
            end
            strobes++;
         end
         if (S_BVALID && bv_cyc < 0) bv_cyc = cyc;
         if (S_BVALID && !S_BREADY) begin
            hold++;
            check("bp_awready", {31'b0, S_AWREADY}, 32'd0);
            check("bp_wready", {31'b0, S_WREADY}, 32'd0);
         end
         if (S_BVALID && S_BREADY) begin
            done = 1'b1;
            if (bq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL bq_empty: unexpected write response");
            end else begin
               e = bq.pop_front();
               check("bresp", {30'b0, S_BRESP}, {30'b0, e});
            end
         end
         aw_f = S_AWVALID && S_AWREADY;
         w_f  = S_WVALID && S_WREADY;
         @(posedge CLK);
         #1;
         if (aw_f) S_AWVALID = 1'b0;
         if (w_f)  S_WVALID  = 1'b0;
         if (wlead > 0 && cyc + 1 == wlead) S_AWVALID = 1'b1;
         if (bv_cyc >= 0 && hold >= bp) S_BREADY = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL bresp_timeout: no write response for addr 0x%0h", a);
      end
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
      S_BREADY  = 1'b1;
      check("w_strobes", strobes, exp_strobes);
      check("b_cycle", bv_cyc, exp_bcyc);
      check("b_hold", hold, bp);
      if (exp_strobes > 0) begin
         check("wenb", {28'b0, s_wenb}, {28'b0, s});
         check("wadr", s_adr, a & 32'hFFFF_FFFC);
         check("wdat", s_dat, d);
         check("wtyp", {22'b0, s_typ}, 32'd5);
      end
   endtask

   task automatic do_read(input logic [31:0] a, input int nwait, input logic [31:0] d, input bit err,
                          input logic [1:0] exp_resp, input logic [31:0] exp_data,
                          input int exp_renb, input int exp_rcyc);
      int          strobes = 0;
      int          rv_cyc = -1;
      bit          done = 1'b0;
      bit          ar_f;
      logic [31:0] s_adr = '0;
      logic [9:0]  s_typ = '0;
      rexp_t       e;
      r_wait_req = nwait;
      r_dat      = d;
      r_err      = err;
      rq.push_back('{resp: exp_resp, data: exp_data});
      S_ARADDR  = a;
      S_ARPROT  = 3'd2;
      S_ARVALID = 1'b1;
      S_RREADY  = 1'b1;
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge CLK);
         if (REGBUS_O.renb) begin
            if (strobes == 0) begin
               s_adr = REGBUS_O.radr;
               s_typ = REGBUS_O.rtyp;
            end
            strobes++;
         end
         if (S_RVALID && rv_cyc < 0) rv_cyc = cyc;
         if (S_RVALID && S_RREADY) begin
            done = 1'b1;
            if (rq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rq_empty: unexpected read response");
            end else begin
               e = rq.pop_front();
               check("rresp", {30'b0, S_RRESP}, {30'b0, e.resp});
               check("rdata", S_RDATA, e.data);
            end
         end
         ar_f = S_ARVALID && S_ARREADY;
         @(posedge CLK);
         #1;
         if (ar_f) S_ARVALID = 1'b0;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL rresp_timeout: no read response for addr 0x%0h", a);
      end
      S_ARVALID = 1'b0;
      check("r_strobes", strobes, exp_renb);
      check("r_cycle", rv_cyc, exp_rcyc);
      check("radr", s_adr, a);
      check("rtyp", {22'b0, s_typ}, 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           addr          data          strb  wlead nwait err  resp           strobes bcyc
      wv[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0,  1'b0, SC_RESP_OKAY,   1, 2};
      wv[1] = '{32'h0000_0014, 32'h0000_0055, 4'h3, 3, 0,  1'b0, SC_RESP_OKAY,   1, 5};
      wv[2] = '{32'h0000_001B, 32'hA1B2_C3D4, 4'h4, 0, 2,  1'b1, SC_RESP_SLVERR, 3, 4};
      wv[3] = '{32'h0000_0030, 32'h1111_2222, 4'h0, 0, 0,  1'b0, SC_RESP_OKAY,   0, 1};
      wv[4] = '{32'h0000_0034, 32'h3333_4444, 4'h8, 0, 20, 1'b1, SC_RESP_DECERR, 8, 9};
      //           addr          nwait rdat          err   resp           data          renb rcyc
      rv[0] = '{32'h0000_0020, 5,   32'h1234_5678, 1'b1, SC_RESP_SLVERR, 32'h1234_5678, 6, 7};
      rv[1] = '{32'h0000_0024, 0,   32'h0000_A5A5, 1'b0, SC_RESP_OKAY,   32'h0000_A5A5, 1, 2};
      rv[2] = '{32'h0000_0028, 100, 32'hFFFF_0000, 1'b0, SC_RESP_DECERR, 32'h0000_0000, 8, 9};
      rv[3] = '{32'h0000_002C, 0,   32'h0000_CAFE, 1'b0, SC_RESP_OKAY,   32'h0000_CAFE, 1, 2};

      // reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_awready", {31'b0, S_AWREADY}, 32'd0);
      check("rst_wready", {31'b0, S_WREADY}, 32'd0);
      check("rst_arready", {31'b0, S_ARREADY}, 32'd0);
      check("rst_bvalid", {31'b0, S_BVALID}, 32'd0);
      check("rst_rvalid", {31'b0, S_RVALID}, 32'd0);
      check("rst_bresp", {30'b0, S_BRESP}, 32'd0);
      check("rst_rresp", {30'b0, S_RRESP}, 32'd0);
      check("rst_rdata", S_RDATA, 32'd0);
      check("rst_regbus_zero", {31'b0, REGBUS_O == '0}, 32'd1);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      check("idle_awready", {31'b0, S_AWREADY}, 32'd1);
      check("idle_arready", {31'b0, S_ARREADY}, 32'd1);

      for (int i = 0; i < 5; i++)
         do_write(wv[i].addr, wv[i].data, wv[i].strb, wv[i].wlead, wv[i].nwait, wv[i].err, 0,
                  wv[i].exp_resp, wv[i].exp_strobes, wv[i].exp_bcyc);

      for (int i = 0; i < 4; i++)
         do_read(rv[i].addr, rv[i].nwait, rv[i].rdat, rv[i].err,
                 rv[i].exp_resp, rv[i].exp_data, rv[i].exp_renb, rv[i].exp_rcyc);

      // concurrent write (BREADY low for 4 cycles) and read
      fork
         do_write(32'h0000_0050, 32'h5A5A_5A5A, 4'hF, 0, 0, 1'b0, 4, SC_RESP_OKAY, 1, 2);
         do_read(32'h0000_0050, 0, 32'h0BAD_F00D, 1'b0, SC_RESP_OKAY, 32'h0BAD_F00D, 1, 2);
      join

      // reset while the write strobe is on the bus
      w_wait_req = 50;
      S_AWADDR   = 32'h0000_0040;
      S_AWPROT   = 3'd0;
      S_WDATA    = 32'h7777_7777;
      S_WSTRB    = 4'hF;
      S_AWVALID  = 1'b1;
      S_WVALID   = 1'b1;
      @(posedge CLK);
      #1;
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
      @(negedge CLK);
      check("mid_wenb", {28'b0, REGBUS_O.wenb}, 32'hF);
      #2;
      RSTn = 1'b0;
      #1;
      check("arst_wenb", {28'b0, REGBUS_O.wenb}, 32'd0);
      check("arst_bvalid", {31'b0, S_BVALID}, 32'd0);
      check("arst_rvalid", {31'b0, S_RVALID}, 32'd0);
      check("arst_awready", {31'b0, S_AWREADY}, 32'd0);
      @(posedge CLK);
      #1;
      RSTn       = 1'b1;
      w_wait_req = 0;
      @(posedge CLK);
      #1;
      do_write(32'h0000_0044, 32'h8888_9999, 4'hF, 0, 0, 1'b0, 0, SC_RESP_OKAY, 1, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
